// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared light codes, fault-cause codes and monitor state encoding.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package traffic_pkg;

  localparam logic [2:0] RED      = 3'b100;
  localparam logic [2:0] GREEN    = 3'b010;
  localparam logic [2:0] YELLOW   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_ILLEGAL_ENC  = 3'd1,
    FC_CONFLICT     = 3'd2,
    FC_BAD_SEQ      = 3'd3,
    FC_SHORT_YELLOW = 3'd4,
    FC_SHORT_GREEN  = 3'd5
  } fault_code_t;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } mon_state_t;

  // True for the three one-hot colour codes the controller may legally drive.
  function automatic logic legal_code(input logic [2:0] code);
    return (code == RED) || (code == GREEN) || (code == YELLOW);
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Light bus from the controller plus the lamp/fault side toward the lamp drivers.
// Latency: n/a (wiring only).
// Backpressure: none; lights are presented every cycle and consumed every cycle.
interface traffic_conflict_monitor_if;
  logic [2:0] NS_light;
  logic [2:0] EW_light;
  logic       emergency;
  logic       fault_clear;
  logic [2:0] NS_lamp;
  logic [2:0] EW_lamp;
  logic       fault;
  logic [2:0] fault_code;

  // Controller / stimulus side.
  modport master (
    output NS_light, EW_light, emergency, fault_clear,
    input  NS_lamp, EW_lamp, fault, fault_code
  );

  // Monitor side.
  modport slave (
    input  NS_light, EW_light, emergency, fault_clear,
    output NS_lamp, EW_lamp, fault, fault_code
  );
endinterface

// File: rtl/traffic_conflict_monitor_seq.sv
// Per-direction sequence and dwell checker: previous colour, dwell count, step rules.
// Latency: flags are combinational on the current light; prev/dwell update at the edge.
// Backpressure: none; one light code consumed every cycle.
module light_seq_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 10,
  parameter int MIN_YELLOW = 10,
  parameter int DMAX       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       arm,
  input  logic       monitor,
  input  logic       exempt,
  output logic       bad_seq,
  output logic       short_green,
  output logic       short_yellow
);

  localparam int DW = $clog2(DMAX + 1);

  logic [2:0]    prev;
  logic [DW-1:0] dwell;
  logic          changed;
  logic          legal_step;

  // ARM loads DMAX so the first observed phase is never judged short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= RED;
      dwell <= DW'(DMAX);
    end else if (arm) begin
      prev  <= light;
      dwell <= DW'(DMAX);
    end else if (monitor) begin
      prev <= light;
      if (light != prev)
        dwell <= DW'(1);
      else if (dwell < DW'(DMAX))
        dwell <= dwell + DW'(1);
    end
  end

  // Dwell holds how long the previous colour was shown, so it is judged on the change cycle.
  always_comb begin
    changed      = (light != prev);
    legal_step   = ((prev == GREEN)  && (light == YELLOW)) ||
                   ((prev == YELLOW) && (light == RED))    ||
                   ((prev == RED)    && (light == GREEN));
    bad_seq      = monitor && !exempt && changed && !legal_step;
    short_green  = monitor && !exempt && (prev == GREEN) && (light == YELLOW) &&
                   (dwell < DW'(MIN_GREEN));
    short_yellow = monitor && !exempt && (prev == YELLOW) && (light == RED) &&
                   (dwell < DW'(MIN_YELLOW));
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the light controller and lamp drivers; latches first fault and flashes red.
// Latency: lamps 0 cycles (pass-through/masking combinational); fault/fault_code 1 cycle.
// Backpressure: none; the controller is never stalled, bad lights are masked instead.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 10,
  parameter int MIN_YELLOW = 10,
  parameter int FLASH_HALF = 8
) (
  input logic                        clk,
  input logic                        rst,
  traffic_conflict_monitor_if.slave  bus
);

  localparam int DMAX = (MIN_GREEN > MIN_YELLOW) ? MIN_GREEN : MIN_YELLOW;
  localparam int FW   = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  mon_state_t  state;
  mon_state_t  state_nxt;
  fault_code_t viol_code;
  fault_code_t fault_code_q;
  logic        fault_q;
  logic        viol;
  logic        illegal_enc;
  logic        conflict;
  logic        exempt;
  logic        clear_ok;
  logic        ns_bad, ns_sg, ns_sy;
  logic        ew_bad, ew_sg, ew_sy;
  logic [FW-1:0] flash_cnt;
  logic        flash_on;
  logic        in_arm;
  logic        in_monitor;

  assign in_arm     = (state == ST_ARM);
  assign in_monitor = (state == ST_MONITOR);

  light_seq_checker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .DMAX      (DMAX)
  ) u_ns (
    .clk         (clk),
    .rst         (rst),
    .light       (bus.NS_light),
    .arm         (in_arm),
    .monitor     (in_monitor),
    .exempt      (exempt),
    .bad_seq     (ns_bad),
    .short_green (ns_sg),
    .short_yellow(ns_sy)
  );

  light_seq_checker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .DMAX      (DMAX)
  ) u_ew (
    .clk         (clk),
    .rst         (rst),
    .light       (bus.EW_light),
    .arm         (in_arm),
    .monitor     (in_monitor),
    .exempt      (exempt),
    .bad_seq     (ew_bad),
    .short_green (ew_sg),
    .short_yellow(ew_sy)
  );

  // Cross-direction checks and lowest-code-wins priority; sequence flags are already gated to MONITOR.
  always_comb begin
    illegal_enc = !legal_code(bus.NS_light) || !legal_code(bus.EW_light);
    conflict    = (bus.NS_light != RED) && (bus.EW_light != RED);
    exempt      = bus.emergency && (bus.NS_light == GREEN) && (bus.EW_light == RED);
    clear_ok    = bus.fault_clear && !illegal_enc && !conflict;
    viol_code   = FC_NONE;
    if (illegal_enc)          viol_code = FC_ILLEGAL_ENC;
    else if (conflict)        viol_code = FC_CONFLICT;
    else if (ns_bad || ew_bad) viol_code = FC_BAD_SEQ;
    else if (ns_sy || ew_sy)  viol_code = FC_SHORT_YELLOW;
    else if (ns_sg || ew_sg)  viol_code = FC_SHORT_GREEN;
    viol = (viol_code != FC_NONE);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ARM;
    else     state <= state_nxt;
  end

  // Next state and lamp mux; ARM and violating MONITOR cycles show all-red.
  always_comb begin
    state_nxt   = state;
    bus.NS_lamp = RED;
    bus.EW_lamp = RED;
    case (state)
      ST_ARM: begin
        state_nxt = viol ? ST_FAULT : ST_MONITOR;
      end
      ST_MONITOR: begin
        if (viol) begin
          state_nxt = ST_FAULT;
        end else begin
          bus.NS_lamp = bus.NS_light;
          bus.EW_lamp = bus.EW_light;
        end
      end
      ST_FAULT: begin
        if (clear_ok) state_nxt = ST_ARM;
        bus.NS_lamp = flash_on ? RED : LAMP_OFF;
        bus.EW_lamp = flash_on ? RED : LAMP_OFF;
      end
      default: state_nxt = ST_ARM;
    endcase
  end

  // First cause is latched; nothing is evaluated in FAULT except an acceptable clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else if ((state != ST_FAULT) && viol) begin
      fault_q      <= 1'b1;
      fault_code_q <= viol_code;
    end else if ((state == ST_FAULT) && clear_ok) begin
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end
  end

  // Flash timer held at phase ON, count 0 outside FAULT so every entry starts lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_cnt <= '0;
      flash_on  <= 1'b1;
    end else if (state != ST_FAULT) begin
      flash_cnt <= '0;
      flash_on  <= 1'b1;
    end else if (flash_cnt == FW'(FLASH_HALF - 1)) begin
      flash_cnt <= '0;
      flash_on  <= ~flash_on;
    end else begin
      flash_cnt <= flash_cnt + FW'(1);
    end
  end

  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: per-cycle expected lamps/fault queued with stimulus.
// Latency: expectations describe outputs during the cycle the inputs are driven.
// Backpressure: n/a.
module tb_traffic_conflict_monitor;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] G   = 3'b010;
  localparam logic [2:0] Y   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       f;
    logic [2:0] c;
  } exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  exp_t exp_cur;

  traffic_conflict_monitor_if bus();

  traffic_conflict_monitor dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: pops one expectation per cycle, 1 time unit before the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() != 0) begin
        exp_cur = exp_q.pop_front();
        cyc++;
        checks += 4;
        if (bus.NS_lamp !== exp_cur.ns) begin
          errors++;
          $display("FAIL ns_lamp cyc=%0d got=%b exp=%b", cyc, bus.NS_lamp, exp_cur.ns);
        end
        if (bus.EW_lamp !== exp_cur.ew) begin
          errors++;
          $display("FAIL ew_lamp cyc=%0d got=%b exp=%b", cyc, bus.EW_lamp, exp_cur.ew);
        end
        if (bus.fault !== exp_cur.f) begin
          errors++;
          $display("FAIL fault cyc=%0d got=%b exp=%b", cyc, bus.fault, exp_cur.f);
        end
        if (bus.fault_code !== exp_cur.c) begin
          errors++;
          $display("FAIL fault_code cyc=%0d got=%0d exp=%0d", cyc, bus.fault_code, exp_cur.c);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] ns, input logic [2:0] ew, input logic em,
                       input logic clr, input logic [2:0] ens, input logic [2:0] eew,
                       input logic ef, input logic [2:0] ec);
    exp_t e;
    @(negedge clk);
    bus.NS_light    = ns;
    bus.EW_light    = ew;
    bus.emergency   = em;
    bus.fault_clear = clr;
    e.ns = ens; e.ew = eew; e.f = ef; e.c = ec;
    exp_q.push_back(e);
  endtask

  // n cycles of legal traffic expected to pass straight through.
  task automatic run_pass(input int n, input logic [2:0] ns, input logic [2:0] ew);
    for (int i = 0; i < n; i++) drive(ns, ew, 1'b0, 1'b0, ns, ew, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.NS_light = G; bus.EW_light = R; bus.emergency = 1'b0; bus.fault_clear = 1'b0;
    #3;
    checks += 3;
    if (bus.NS_lamp !== R || bus.EW_lamp !== R) begin
      errors++; $display("FAIL reset_lamps got=%b/%b exp=100/100", bus.NS_lamp, bus.EW_lamp);
    end
    if (bus.fault !== 1'b0) begin
      errors++; $display("FAIL reset_fault got=%b exp=0", bus.fault);
    end
    if (bus.fault_code !== 3'd0) begin
      errors++; $display("FAIL reset_code got=%0d exp=0", bus.fault_code);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_standard();
    drive(G, R, 1'b0, 1'b0, R, R, 1'b0, 3'd0);  // ARM
    for (int k = 0; k < 2; k++) begin
      run_pass(10, G, R);
      run_pass(10, Y, R);
      run_pass(10, R, G);
      run_pass(10, R, Y);
    end
  endtask

  task automatic test_conflict();
    drive(G, G, 1'b0, 1'b0, R, R, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) drive(G, R, 1'b0, 1'b0, R, R, 1'b1, 3'd2);
    for (int i = 0; i < 8; i++) drive(G, R, 1'b0, 1'b0, OFF, OFF, 1'b1, 3'd2);
  endtask

  task automatic test_clear();
    drive(3'b011, R, 1'b0, 1'b1, R, R, 1'b1, 3'd2);  // rejected: illegal NS
    drive(G, R, 1'b0, 1'b0, R, R, 1'b1, 3'd2);
    drive(G, R, 1'b0, 1'b1, R, R, 1'b1, 3'd2);       // accepted
    drive(G, R, 1'b0, 1'b1, R, R, 1'b0, 3'd0);       // single ARM cycle
    drive(G, R, 1'b0, 1'b1, G, R, 1'b0, 3'd0);       // held clear ignored in MONITOR
  endtask

  task automatic test_short_yellow();
    run_pass(9, G, R);
    run_pass(9, Y, R);
    drive(R, R, 1'b0, 1'b0, R, R, 1'b0, 3'd0);
    drive(R, R, 1'b0, 1'b0, R, R, 1'b1, 3'd4);
    drive(R, R, 1'b0, 1'b0, R, R, 1'b1, 3'd4);
    drive(R, R, 1'b0, 1'b1, R, R, 1'b1, 3'd4);
    drive(R, G, 1'b0, 1'b0, R, R, 1'b0, 3'd0);       // ARM
  endtask

  task automatic test_emergency();
    run_pass(3, R, G);
    drive(G, R, 1'b1, 1'b0, G, R, 1'b0, 3'd0);       // EW G->R exempted
    run_pass(9, G, R);
    run_pass(10, Y, R);
    run_pass(4, R, G);
    drive(G, R, 1'b0, 1'b0, R, R, 1'b0, 3'd0);       // same step without emergency
    drive(G, R, 1'b0, 1'b0, R, R, 1'b1, 3'd3);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) drive(G, R, 1'b0, 1'b0, R, R, 1'b1, 3'd3);
    for (int i = 0; i < 2; i++) drive(G, R, 1'b0, 1'b0, OFF, OFF, 1'b1, 3'd3);
    @(negedge clk);
    #1;
    checks++;
    if (bus.NS_lamp !== OFF || bus.fault !== 1'b1) begin
      errors++; $display("FAIL pre_rst_flash got=%b/%b exp=000/1", bus.NS_lamp, bus.fault);
    end
    rst = 1'b1;
    #1;
    checks += 3;
    if (bus.NS_lamp !== R || bus.EW_lamp !== R) begin
      errors++; $display("FAIL async_rst_lamps got=%b/%b exp=100/100", bus.NS_lamp, bus.EW_lamp);
    end
    if (bus.fault !== 1'b0) begin
      errors++; $display("FAIL async_rst_fault got=%b exp=0", bus.fault);
    end
    if (bus.fault_code !== 3'd0) begin
      errors++; $display("FAIL async_rst_code got=%0d exp=0", bus.fault_code);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_short_green();
    drive(R, G, 1'b0, 1'b0, R, R, 1'b0, 3'd0);       // ARM
    run_pass(9, R, G);
    run_pass(10, R, Y);
    run_pass(5, G, R);
    drive(Y, R, 1'b0, 1'b0, R, R, 1'b0, 3'd0);
    drive(Y, R, 1'b0, 1'b0, R, R, 1'b1, 3'd5);
  endtask

  initial begin
    test_reset();
    test_standard();
    test_conflict();
    test_clear();
    test_short_yellow();
    test_emergency();
    test_async_reset();
    test_short_green();
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
